// File: rtl/interp_rate_ctrl_pkg.sv
// interp_ctrl_pkg: state encoding, default ratios and phase-width helper for
// the Tx interpolation rate controller.
`default_nettype none

package interp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int DEF_RATIO_HB      = 2;
  localparam int DEF_RATIO_CIC     = 8;
  localparam int DEF_P             = DEF_RATIO_HB * DEF_RATIO_CIC;
  localparam int DEF_FILL_SAMPLES  = 12;
  localparam int DEF_DRAIN_SAMPLES = 12;
  localparam int DEF_CNT_W         = 16;

  function automatic int ph_width(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/interp_rate_ctrl_if.sv
// interp_rate_ctrl_if: control/handshake bundle of the interpolation rate controller.
// Macro INTERP_CTRL_UNDERFLOW_CNT_EN adds the saturating underflow counter.
`default_nettype none

interface interp_rate_ctrl_if
`ifdef INTERP_CTRL_UNDERFLOW_CNT_EN
  #(parameter int CNT_W = 16)
`endif
  ;
  logic       i_start;
  logic       i_stop;
  logic       i_in_valid;
  logic       i_clr_underflow;
  logic       o_in_ready;
  logic       o_ce_in;
  logic       o_ce_mid;
  logic       o_ce_out;
  logic       o_zero_stuff;
  logic       o_out_valid;
  logic       o_busy;
  logic [1:0] o_state;
  logic       o_underflow;
`ifdef INTERP_CTRL_UNDERFLOW_CNT_EN
  logic [CNT_W-1:0] o_underflow_cnt;
`endif

  modport master (
    output i_start, i_stop, i_in_valid, i_clr_underflow,
    input  o_in_ready, o_ce_in, o_ce_mid, o_ce_out, o_zero_stuff,
           o_out_valid, o_busy, o_state, o_underflow
`ifdef INTERP_CTRL_UNDERFLOW_CNT_EN
         , o_underflow_cnt
`endif
  );

  modport slave (
    input  i_start, i_stop, i_in_valid, i_clr_underflow,
    output o_in_ready, o_ce_in, o_ce_mid, o_ce_out, o_zero_stuff,
           o_out_valid, o_busy, o_state, o_underflow
`ifdef INTERP_CTRL_UNDERFLOW_CNT_EN
         , o_underflow_cnt
`endif
  );

endinterface

`default_nettype wire

// File: rtl/interp_rate_ctrl_ce_gen.sv
// interp_ce_gen: phase counter and per-stage clock-enable decode.
`default_nettype none

module interp_ce_gen
  import interp_ctrl_pkg::*;
#(
  parameter int RATIO_HB  = DEF_RATIO_HB,
  parameter int RATIO_CIC = DEF_RATIO_CIC
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_restart,
  output logic o_ce_in,
  output logic o_ce_mid,
  output logic o_ce_out,
  output logic o_boundary
);

  localparam int P     = RATIO_HB * RATIO_CIC;
  localparam int PH_W  = ph_width(P);
  localparam int MID_W = ph_width(RATIO_CIC);
  localparam logic [PH_W-1:0]  c_PH_LAST  = PH_W'(P - 1);
  localparam logic [MID_W-1:0] c_MID_LAST = MID_W'(RATIO_CIC - 1);

  logic [PH_W-1:0]  r_ph;
  logic [MID_W-1:0] r_mid;

  // r_mid runs in lockstep with r_ph so ce_mid needs no modulo; P is a multiple of RATIO_CIC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ph  <= '0;
      r_mid <= '0;
    end else if (i_restart) begin
      r_ph  <= '0;
      r_mid <= '0;
    end else if (i_active) begin
      r_ph  <= (r_ph == c_PH_LAST)   ? '0 : r_ph + 1'b1;
      r_mid <= (r_mid == c_MID_LAST) ? '0 : r_mid + 1'b1;
    end
  end

  assign o_ce_in    = i_active && (r_ph == '0);
  assign o_ce_mid   = i_active && (r_mid == '0);
  assign o_ce_out   = i_active;
  assign o_boundary = i_active && (r_ph == c_PH_LAST);

endmodule

`default_nettype wire

// File: rtl/interp_rate_ctrl.sv
// interp_rate_ctrl: sequences the x2 HB + x8 CIC Tx interpolation chain (fill/run/drain).
// Macro INTERP_CTRL_UNDERFLOW_CNT_EN adds o_underflow_cnt (saturating).
`default_nettype none

module interp_rate_ctrl
  import interp_ctrl_pkg::*;
#(
  parameter int RATIO_HB      = DEF_RATIO_HB,
  parameter int RATIO_CIC     = DEF_RATIO_CIC,
  parameter int FILL_SAMPLES  = DEF_FILL_SAMPLES,
  parameter int DRAIN_SAMPLES = DEF_DRAIN_SAMPLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  interp_rate_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] c_FILL_N  = CNT_W'(FILL_SAMPLES);
  localparam logic [CNT_W-1:0] c_DRAIN_N = CNT_W'(DRAIN_SAMPLES);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_slot;
  logic             r_stop_pend;
  logic             r_drain_ov;
  logic             r_underflow;
  logic             w_active;
  logic             w_stream;
  logic             w_restart;
  logic             w_state_chg;
  logic             w_ce_in;
  logic             w_ce_mid;
  logic             w_ce_out;
  logic             w_boundary;
  logic             w_in_ready;
  logic             w_zero_stuff;
  logic             w_uf_event;
  logic             w_out_valid;

  assign w_active = (r_state != ST_IDLE);

  interp_ce_gen #(
    .RATIO_HB  (RATIO_HB),
    .RATIO_CIC (RATIO_CIC)
  ) u_ce_gen (
    .clk        (clk),
    .rst        (rst),
    .i_active   (w_active),
    .i_restart  (w_restart),
    .o_ce_in    (w_ce_in),
    .o_ce_mid   (w_ce_mid),
    .o_ce_out   (w_ce_out),
    .o_boundary (w_boundary)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (bus.i_start) w_state_nxt = ST_FILL;
      ST_FILL: begin
        if (w_boundary) begin
          if (r_stop_pend)          w_state_nxt = ST_DRAIN;
          else if (r_slot >= c_FILL_N) w_state_nxt = ST_RUN;
        end
      end
      ST_RUN:   if (w_boundary && r_stop_pend) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_boundary && (r_slot >= c_DRAIN_N)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_stream     = (r_state == ST_FILL) || (r_state == ST_RUN);
    w_restart    = (r_state == ST_IDLE) && (w_state_nxt == ST_FILL);
    w_state_chg  = (w_state_nxt != r_state);
    w_in_ready   = w_ce_in && w_stream;
    w_zero_stuff = 1'b0;
    if (r_state == ST_DRAIN)
      w_zero_stuff = w_ce_in;
    else if (w_stream)
      w_zero_stuff = w_ce_in && !bus.i_in_valid;
    w_uf_event   = (r_state == ST_RUN) && w_zero_stuff;
    // A drain entered straight from FILL flushes a pipeline that never produced valid output
    w_out_valid  = (r_state == ST_RUN) || ((r_state == ST_DRAIN) && r_drain_ov);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_slot      <= '0;
      r_stop_pend <= 1'b0;
      r_drain_ov  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_chg) begin
        r_slot      <= '0;
        r_stop_pend <= 1'b0;
        r_drain_ov  <= (r_state == ST_RUN);
      end else begin
        if (w_ce_in)               r_slot      <= r_slot + 1'b1;
        if (bus.i_stop && w_stream) r_stop_pend <= 1'b1;
      end
      if (w_uf_event)               r_underflow <= 1'b1;
      else if (bus.i_clr_underflow) r_underflow <= 1'b0;
    end
  end

`ifdef INTERP_CTRL_UNDERFLOW_CNT_EN
  logic [CNT_W-1:0] r_uf_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_uf_cnt <= '0;
    end else if (w_uf_event) begin
      if (bus.i_clr_underflow)  r_uf_cnt <= CNT_W'(1);
      else if (r_uf_cnt != '1)  r_uf_cnt <= r_uf_cnt + 1'b1;
    end else if (bus.i_clr_underflow) begin
      r_uf_cnt <= '0;
    end
  end

  assign bus.o_underflow_cnt = r_uf_cnt;
`endif

  assign bus.o_in_ready   = w_in_ready;
  assign bus.o_ce_in      = w_ce_in;
  assign bus.o_ce_mid     = w_ce_mid;
  assign bus.o_ce_out     = w_ce_out;
  assign bus.o_zero_stuff = w_zero_stuff;
  assign bus.o_out_valid  = w_out_valid;
  assign bus.o_busy       = w_active;
  assign bus.o_state      = r_state;
  assign bus.o_underflow  = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_interp_rate_ctrl.sv
// tb_interp_rate_ctrl: directed self-checking bench for interp_rate_ctrl.
// Build with INTERP_CTRL_UNDERFLOW_CNT_EN to also exercise the counter (CNT_W=4).
`default_nettype none

module tb_interp_rate_ctrl;

  localparam int P = 16;
`ifdef INTERP_CTRL_UNDERFLOW_CNT_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   t       = 0;

  always #5 clk = ~clk;

`ifdef INTERP_CTRL_UNDERFLOW_CNT_EN
  interp_rate_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();
`else
  interp_rate_ctrl_if bus ();
`endif

  interp_rate_ctrl #(
    .RATIO_HB      (2),
    .RATIO_CIC     (8),
    .FILL_SAMPLES  (12),
    .DRAIN_SAMPLES (12),
    .CNT_W         (TB_CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {in_ready, ce_in, ce_mid, ce_out, zero_stuff, out_valid, busy, underflow, state}
  logic [9:0] outs;
  assign outs = {bus.o_in_ready, bus.o_ce_in, bus.o_ce_mid, bus.o_ce_out, bus.o_zero_stuff,
                 bus.o_out_valid, bus.o_busy, bus.o_underflow, bus.o_state};

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic do_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    t = 0;
  endtask

  task automatic advance_to(input int ph);
    while ((t % P) != ph) tick();
  endtask

  task automatic test_reset();
    bus.i_start = 1'b1; bus.i_stop = 1'b1; bus.i_in_valid = 1'b1; bus.i_clr_underflow = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (outs !== 10'h000) begin
      n_fail++; $display("FAIL reset_outs: got %h expected 000", outs);
    end
    bus.i_start = 1'b0; bus.i_stop = 1'b0;
    rst = 1'b0;
    tick(); #1;
    n_tests++;
    if (outs !== 10'h000) begin
      n_fail++; $display("FAIL idle_after_reset: got %h expected 000", outs);
    end
  endtask

  task automatic test_fill_run();
    logic [9:0] exp;
    bus.i_in_valid = 1'b1;
    do_start();
    for (int k = 0; k < 200; k++) begin
      #1;
      exp = {(t % 16) == 0, (t % 16) == 0, (t % 8) == 0, 1'b1, 1'b0,
             t >= 192, 1'b1, 1'b0, (t >= 192) ? 2'd2 : 2'd1};
      n_tests++;
      if (outs !== exp) begin
        n_fail++; $display("FAIL fill_run t=%0d: got %h expected %h", t, outs, exp);
      end
      tick();
    end
  endtask

  task automatic test_underflow();
    advance_to(15);
    tick();
    bus.i_in_valid = 1'b0;
    #1;
    n_tests++;
    if ({bus.o_zero_stuff, bus.o_in_ready, bus.o_underflow, bus.o_state} !== 5'b110_10) begin
      n_fail++; $display("FAIL starve_slot: got %b expected 11010",
                         {bus.o_zero_stuff, bus.o_in_ready, bus.o_underflow, bus.o_state});
    end
    tick();
    bus.i_in_valid = 1'b1;
    #1;
    n_tests++;
    if (bus.o_underflow !== 1'b1) begin
      n_fail++; $display("FAIL underflow_set: got %b expected 1", bus.o_underflow);
    end
    repeat (20) tick();
    n_tests++;
    if (bus.o_underflow !== 1'b1) begin
      n_fail++; $display("FAIL underflow_sticky: got %b expected 1", bus.o_underflow);
    end
    bus.i_clr_underflow = 1'b1;
    tick();
    bus.i_clr_underflow = 1'b0;
    #1;
    n_tests++;
    if (bus.o_underflow !== 1'b0) begin
      n_fail++; $display("FAIL underflow_clr: got %b expected 0", bus.o_underflow);
    end
    // starved slot and clear in the same cycle: set must win
    advance_to(15);
    tick();
    bus.i_in_valid = 1'b0;
    bus.i_clr_underflow = 1'b1;
    tick();
    bus.i_in_valid = 1'b1;
    bus.i_clr_underflow = 1'b0;
    #1;
    n_tests++;
    if (bus.o_underflow !== 1'b1) begin
      n_fail++; $display("FAIL set_beats_clr: got %b expected 1", bus.o_underflow);
    end
    bus.i_clr_underflow = 1'b1;
    tick();
    bus.i_clr_underflow = 1'b0;
  endtask

`ifdef INTERP_CTRL_UNDERFLOW_CNT_EN
  task automatic test_underflow_cnt();
    n_tests++;
    if (bus.o_underflow_cnt !== 4'd0) begin
      n_fail++; $display("FAIL ucnt_start: got %0d expected 0", bus.o_underflow_cnt);
    end
    advance_to(15);
    tick();
    bus.i_in_valid = 1'b0;
    repeat (20 * P) tick();
    bus.i_in_valid = 1'b1;
    #1;
    n_tests++;
    if (bus.o_underflow_cnt !== 4'd15) begin
      n_fail++; $display("FAIL ucnt_saturate: got %0d expected 15", bus.o_underflow_cnt);
    end
    bus.i_clr_underflow = 1'b1;
    tick();
    bus.i_clr_underflow = 1'b0;
    #1;
    n_tests++;
    if ({bus.o_underflow_cnt, bus.o_underflow} !== 5'd0) begin
      n_fail++; $display("FAIL ucnt_clr: got cnt=%0d flag=%b expected 0/0",
                         bus.o_underflow_cnt, bus.o_underflow);
    end
  endtask
`endif

  task automatic test_stop_run();
    int zs = 0;
    int rd = 0;
    bus.i_in_valid = 1'b1;
    advance_to(5);
    bus.i_stop = 1'b1;
    tick();
    bus.i_stop = 1'b0;
    advance_to(15);
    #1;
    n_tests++;
    if (bus.o_state !== 2'd2) begin
      n_fail++; $display("FAIL stop_pending_run: got state %0d expected 2", bus.o_state);
    end
    tick(); #1;
    n_tests++;
    if (outs !== 10'b0_1111_1101_1) begin
      n_fail++; $display("FAIL drain_entry: got %b expected 0111111011", outs);
    end
    for (int d = 0; d < 192; d++) begin
      if (d != 0) begin tick(); #1; end
      zs += int'(bus.o_zero_stuff);
      rd += int'(bus.o_in_ready);
      n_tests++;
      if (bus.o_busy !== 1'b1) begin
        n_fail++; $display("FAIL drain_busy d=%0d: got %b expected 1", d, bus.o_busy);
      end
    end
    tick(); #1;
    n_tests++;
    if ({bus.o_busy, bus.o_out_valid, bus.o_state} !== 4'b0000) begin
      n_fail++; $display("FAIL drain_idle: got busy=%b ov=%b state=%0d expected 0/0/0",
                         bus.o_busy, bus.o_out_valid, bus.o_state);
    end
    n_tests++;
    if (zs != 12 || rd != 0) begin
      n_fail++; $display("FAIL drain_slots: got zs=%0d ready=%0d expected 12/0", zs, rd);
    end
  endtask

  task automatic test_stop_fill();
    logic seen_ov = 1'b0;
    logic done    = 1'b0;
    int   dt      = -1;
    do_start();
    for (int k = 0; k < 400 && !done; k++) begin
      bus.i_stop = (t == 70);
      #1;
      seen_ov |= bus.o_out_valid;
      if (bus.o_state == 2'd3 && dt < 0) dt = t;
      if (!bus.o_busy) done = 1'b1;
      else tick();
    end
    bus.i_stop = 1'b0;
    n_tests++;
    if (!done || t != 272) begin
      n_fail++; $display("FAIL fill_stop_idle: got done=%b t=%0d expected 1/272", done, t);
    end
    n_tests++;
    if (dt != 80) begin
      n_fail++; $display("FAIL fill_stop_drain: got drain at t=%0d expected 80", dt);
    end
    n_tests++;
    if (seen_ov !== 1'b0) begin
      n_fail++; $display("FAIL fill_stop_ov: got out_valid seen=%b expected 0", seen_ov);
    end
  endtask

  task automatic test_start_busy();
    logic done = 1'b0;
    bus.i_start = 1'b1;
    bus.i_stop  = 1'b1;
    tick();
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    t = 0;
    #1;
    n_tests++;
    if ({bus.o_state, bus.o_ce_in} !== 3'b01_1) begin
      n_fail++; $display("FAIL start_stop_idle: got state=%0d ce_in=%b expected 1/1",
                         bus.o_state, bus.o_ce_in);
    end
    while (t < 20) tick();
    #1;
    n_tests++;
    if (bus.o_state !== 2'd1) begin
      n_fail++; $display("FAIL stop_in_idle_ignored: got state %0d expected 1", bus.o_state);
    end
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    #1;
    n_tests++;
    if (bus.o_ce_in !== 1'b0) begin
      n_fail++; $display("FAIL start_busy_ignored: got ce_in %b expected 0", bus.o_ce_in);
    end
    while (t < 32) tick();
    #1;
    n_tests++;
    if ({bus.o_state, bus.o_ce_in} !== 3'b01_1) begin
      n_fail++; $display("FAIL start_busy_phase: got state=%0d ce_in=%b expected 1/1",
                         bus.o_state, bus.o_ce_in);
    end
    tick();
    bus.i_stop = 1'b1;
    tick();
    bus.i_stop = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      #1;
      if (!bus.o_busy) done = 1'b1;
      else tick();
    end
    n_tests++;
    if (!done || t != 240) begin
      n_fail++; $display("FAIL start_busy_idle: got done=%b t=%0d expected 1/240", done, t);
    end
  endtask

  task automatic test_reset_mid();
    bus.i_in_valid = 1'b1;
    do_start();
    while (t < 201) tick();
    #1;
    n_tests++;
    if (bus.o_state !== 2'd2) begin
      n_fail++; $display("FAIL rst_mid_pre: got state %0d expected 2", bus.o_state);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (outs !== 10'h000) begin
      n_fail++; $display("FAIL rst_mid_outs: got %h expected 000", outs);
    end
    tick();
    rst = 1'b0;
    tick(); #1;
    n_tests++;
    if (outs !== 10'h000) begin
      n_fail++; $display("FAIL rst_mid_idle: got %h expected 000", outs);
    end
    do_start();
    #1;
    n_tests++;
    if ({bus.o_ce_in, bus.o_in_ready, bus.o_state} !== 4'b11_01) begin
      n_fail++; $display("FAIL restart_ce_in: got ce_in=%b ready=%b state=%0d expected 1/1/1",
                         bus.o_ce_in, bus.o_in_ready, bus.o_state);
    end
    while (t < 8) tick();
    #1;
    n_tests++;
    if ({bus.o_ce_in, bus.o_ce_mid} !== 2'b01) begin
      n_fail++; $display("FAIL restart_mid: got ce_in=%b ce_mid=%b expected 0/1",
                         bus.o_ce_in, bus.o_ce_mid);
    end
    while (t < 16) tick();
    #1;
    n_tests++;
    if (bus.o_ce_in !== 1'b1) begin
      n_fail++; $display("FAIL restart_slot2: got ce_in=%b expected 1", bus.o_ce_in);
    end
  endtask

  initial begin
    test_reset();
    test_fill_run();
    test_underflow();
`ifdef INTERP_CTRL_UNDERFLOW_CNT_EN
    test_underflow_cnt();
`endif
    test_stop_run();
    test_stop_fill();
    test_start_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
